// File: rtl/pipelined_control_pkg.sv
// Shared definitions for the pipelined control unit: opcode map, the
// per-stage control bundle and the bubble bundle loaded on stall/flush/reset.
package pipelined_control_pkg;

  localparam int PKG_REG_ADDR_W = 4;
  localparam int PKG_CMP_W      = 2;
  localparam int PKG_ALU_CTRL_W = PKG_CMP_W + 4;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_MAX = 4'h7;
  localparam logic [3:0] OP_CMP = 4'h8;
  localparam logic [3:0] OP_SLL = 4'h9;
  localparam logic [3:0] OP_SRL = 4'hA;
  localparam logic [3:0] OP_MOV = 4'hB;
  localparam logic [3:0] OP_LD  = 4'hC;
  localparam logic [3:0] OP_ST  = 4'hD;
  localparam logic [3:0] OP_BT  = 4'hE;
  localparam logic [3:0] OP_NOP = 4'hF;

  localparam logic [1:0] SEL_B_ALU   = 2'd0;
  localparam logic [1:0] SEL_B_LOAD  = 2'd1;
  localparam logic [1:0] SEL_B_STORE = 2'd2;

  typedef struct packed {
    logic [PKG_ALU_CTRL_W-1:0] alu_control;
    logic [1:0]                sel_b;
    logic                      alu_mux;
    logic                      cmp_en;
    logic                      branch;
    logic                      mem_we;
    logic                      mem_re;
    logic                      reg_we;
    logic                      sel_data_out;
    logic [PKG_REG_ADDR_W-1:0] rd;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t BUBBLE = '{
    alu_control:  {{PKG_CMP_W{1'b0}}, OP_NOP},
    sel_b:        SEL_B_ALU,
    alu_mux:      1'b0,
    cmp_en:       1'b0,
    branch:       1'b0,
    mem_we:       1'b0,
    mem_re:       1'b0,
    reg_we:       1'b0,
    sel_data_out: 1'b0,
    rd:           '0
  };

endpackage

// File: rtl/pipelined_control_decode.sv
// Combinational ID-stage decoder: opcode/compare mode/rd to control bundle,
// plus register-file read enables. Invalid slots and NOP decode as the bubble.
module ctrl_decode
  import pipelined_control_pkg::*;
(
  input  logic                      i_valid,
  input  logic [3:0]                i_opcode,
  input  logic [PKG_CMP_W-1:0]      i_cmp_flag,
  input  logic [PKG_REG_ADDR_W-1:0] i_rd,
  output ctrl_bundle_t              o_bundle,
  output logic                      o_re_a,
  output logic                      o_re_b
);

  logic w_is_cmp, w_is_mov, w_is_ld, w_is_st, w_is_bt, w_is_not;

  assign w_is_cmp = (i_opcode == OP_CMP);
  assign w_is_mov = (i_opcode == OP_MOV);
  assign w_is_ld  = (i_opcode == OP_LD);
  assign w_is_st  = (i_opcode == OP_ST);
  assign w_is_bt  = (i_opcode == OP_BT);
  assign w_is_not = (i_opcode == OP_NOT);

  always_comb begin
    o_bundle = BUBBLE;
    o_re_a   = 1'b0;
    o_re_b   = 1'b0;
    if (i_valid && (i_opcode != OP_NOP)) begin
      o_bundle.alu_control  = {i_cmp_flag, i_opcode};
      o_bundle.sel_b        = w_is_ld ? SEL_B_LOAD : (w_is_st ? SEL_B_STORE : SEL_B_ALU);
      o_bundle.alu_mux      = w_is_mov;
      o_bundle.cmp_en       = w_is_cmp;
      o_bundle.branch       = w_is_bt;
      o_bundle.mem_we       = w_is_st;
      o_bundle.mem_re       = w_is_ld;
      o_bundle.reg_we       = !(w_is_cmp || w_is_st || w_is_bt);
      o_bundle.sel_data_out = w_is_ld;
      o_bundle.rd           = i_rd;
      o_re_a                = !(w_is_mov || w_is_bt);
      o_re_b                = !(w_is_not || w_is_mov || w_is_ld || w_is_bt);
    end
  end

endmodule

// File: rtl/pipelined_control.sv
// Pipelined control unit: ID decode carried through EX/MEM/WB with load-use
// stall, taken-branch flush and mem_busy freeze. PIPE_CTRL_PERF_CNT_EN adds stall/flush counters.
module pipelined_control
  import pipelined_control_pkg::*;
#(
  parameter int REG_ADDR_W   = PKG_REG_ADDR_W,
  parameter int CMP_W        = PKG_CMP_W,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [3:0]            id_opcode,
  input  logic [CMP_W-1:0]      id_cmp_flag,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [REG_ADDR_W-1:0] id_ra,
  input  logic [REG_ADDR_W-1:0] id_rb,
  input  logic                  branch_cond,
  input  logic                  mem_busy,
  output logic                  id_re_a,
  output logic                  id_re_b,
  output logic                  stall_out,
  output logic                  flush_out,
  output logic [CMP_W+3:0]      ex_alu_control,
  output logic [1:0]            ex_sel_b,
  output logic                  ex_alu_mux,
  output logic                  ex_cmp_en,
  output logic                  ex_branch,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic                  wb_reg_we,
  output logic                  wb_sel_data_out,
`ifdef PIPE_CTRL_PERF_CNT_EN
  output logic [15:0]           stall_cnt,
  output logic [15:0]           flush_cnt,
`endif
  output logic [REG_ADDR_W-1:0] wb_rd
);

  // Counter holds the bubbles still owed after the taken-branch cycle itself.
  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

  ctrl_bundle_t w_id_bundle;
  ctrl_bundle_t r_ex, r_mem, r_wb;
  logic [1:0]   r_flush_cnt;
  logic         w_load_use, w_taken, w_flush;

  ctrl_decode u_decode (
    .i_valid    (id_valid),
    .i_opcode   (id_opcode),
    .i_cmp_flag (id_cmp_flag),
    .i_rd       (id_rd),
    .o_bundle   (w_id_bundle),
    .o_re_a     (id_re_a),
    .o_re_b     (id_re_b)
  );

  assign w_load_use = r_ex.mem_re &&
                      (((r_ex.rd == id_ra) && id_re_a) || ((r_ex.rd == id_rb) && id_re_b));
  assign w_taken    = r_ex.branch && branch_cond;
  assign w_flush    = w_taken || (r_flush_cnt != 2'd0);

  assign flush_out = w_flush && !mem_busy;
  assign stall_out = mem_busy || (w_load_use && !w_flush);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex        <= BUBBLE;
      r_mem       <= BUBBLE;
      r_wb        <= BUBBLE;
      r_flush_cnt <= 2'd0;
    end else if (!mem_busy) begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= (w_flush || w_load_use) ? BUBBLE : w_id_bundle;
      if (w_taken)
        r_flush_cnt <= FLUSH_RELOAD;
      else if (r_flush_cnt != 2'd0)
        r_flush_cnt <= r_flush_cnt - 2'd1;
    end
  end

  assign ex_alu_control  = r_ex.alu_control;
  assign ex_sel_b        = r_ex.sel_b;
  assign ex_alu_mux      = r_ex.alu_mux;
  assign ex_cmp_en       = r_ex.cmp_en;
  assign ex_branch       = r_ex.branch;
  assign mem_we          = r_mem.mem_we;
  assign mem_re          = r_mem.mem_re;
  assign wb_reg_we       = r_wb.reg_we;
  assign wb_sel_data_out = r_wb.sel_data_out;
  assign wb_rd           = r_wb.rd;

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [15:0] r_stall_cnt, r_flush_cnt_perf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt      <= 16'd0;
      r_flush_cnt_perf <= 16'd0;
    end else begin
      if (stall_out && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
      if (flush_out && (r_flush_cnt_perf != 16'hFFFF))
        r_flush_cnt_perf <= r_flush_cnt_perf + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt_perf;
`endif

endmodule

// File: tb/tb_pipelined_control.sv
// Directed self-checking bench for pipelined_control (FLUSH_CYCLES=2).
`define CHK(tag, obs, exp) chk(tag, 8'(obs), 8'(exp))
module tb_pipelined_control;

  localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, OR_ = 4'h4, NOT_ = 4'h6, CMP = 4'h8;
  localparam logic [3:0] MOV = 4'hB, LD = 4'hC, ST = 4'hD, BT = 4'hE, NOP = 4'hF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [3:0] id_opcode = NOP;
  logic [1:0] id_cmp_flag = 2'b00;
  logic [3:0] id_rd = 4'd0, id_ra = 4'd0, id_rb = 4'd0;
  logic       branch_cond = 1'b0;
  logic       mem_busy = 1'b0;
  logic       id_re_a, id_re_b, stall_out, flush_out;
  logic [5:0] ex_alu_control;
  logic [1:0] ex_sel_b;
  logic       ex_alu_mux, ex_cmp_en, ex_branch, mem_we, mem_re;
  logic       wb_reg_we, wb_sel_data_out;
  logic [3:0] wb_rd;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pipelined_control #(.REG_ADDR_W(4), .CMP_W(2), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_cmp_flag(id_cmp_flag), .id_rd(id_rd), .id_ra(id_ra), .id_rb(id_rb),
    .branch_cond(branch_cond), .mem_busy(mem_busy), .id_re_a(id_re_a),
    .id_re_b(id_re_b), .stall_out(stall_out), .flush_out(flush_out),
    .ex_alu_control(ex_alu_control), .ex_sel_b(ex_sel_b), .ex_alu_mux(ex_alu_mux),
    .ex_cmp_en(ex_cmp_en), .ex_branch(ex_branch), .mem_we(mem_we), .mem_re(mem_re),
    .wb_reg_we(wb_reg_we), .wb_sel_data_out(wb_sel_data_out), .wb_rd(wb_rd)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic id(input logic v, input logic [3:0] op, input logic [1:0] cmp,
                    input logic [3:0] rd, input logic [3:0] ra, input logic [3:0] rb);
    id_valid = v; id_opcode = op; id_cmp_flag = cmp; id_rd = rd; id_ra = ra; id_rb = rb;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      total++;
      if ((stall_out & flush_out) !== 1'b0) begin
        bad++;
        $error("FAIL inv_stall_flush observed=%0b%0b expected=not both", stall_out, flush_out);
      end
      total++;
      if ((mem_we & mem_re) !== 1'b0) begin
        bad++;
        $error("FAIL inv_mem_we_re observed=%0b%0b expected=not both", mem_we, mem_re);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    `CHK("rst_ex_alu", ex_alu_control, 8'h0F);
    `CHK("rst_mem_we", mem_we, 0);
    `CHK("rst_mem_re", mem_re, 0);
    `CHK("rst_wb_we", wb_reg_we, 0);
    `CHK("rst_stall", stall_out, 0);
    `CHK("rst_flush", flush_out, 0);
    @(negedge clk);
    rst = 1'b0;

    id(1, ADD, 2'b00, 4'd3, 4'd1, 4'd2); #1;
    `CHK("add_re_a", id_re_a, 1);
    `CHK("add_re_b", id_re_b, 1);
    `CHK("add_stall0", stall_out, 0);
    tick; id(0, NOP, 0, 0, 0, 0); #1;
    `CHK("add_ex_alu", ex_alu_control, 8'h00);
    `CHK("add_stall1", stall_out, 0);
    tick; #1;
    `CHK("add_mem_we", mem_we, 0);
    `CHK("add_stall2", stall_out, 0);
    tick; #1;
    `CHK("add_wb_we", wb_reg_we, 1);
    `CHK("add_wb_rd", wb_rd, 3);
    `CHK("add_wb_sel", wb_sel_data_out, 0);

    id(1, MOV, 0, 1, 2, 3); #1;
    `CHK("mov_re_a", id_re_a, 0);
    `CHK("mov_re_b", id_re_b, 0);
    id(1, NOT_, 0, 1, 2, 3); #1;
    `CHK("not_re_a", id_re_a, 1);
    `CHK("not_re_b", id_re_b, 0);
    id(0, ADD, 0, 1, 2, 3); #1;
    `CHK("inval_re_a", id_re_a, 0);
    id(1, CMP, 2'b11, 9, 2, 3);
    tick; id(1, MOV, 0, 1, 0, 0); #1;
    `CHK("cmp_ex_alu", ex_alu_control, 8'h38);
    `CHK("cmp_en", ex_cmp_en, 1);
    tick; id(0, NOP, 0, 0, 0, 0); #1;
    `CHK("mov_ex_alu", ex_alu_control, 8'h0B);
    `CHK("mov_alu_mux", ex_alu_mux, 1);

    id(1, LD, 0, 5, 1, 0); #1;
    `CHK("ld_re_b", id_re_b, 0);
    `CHK("ld_stall_id", stall_out, 0);
    tick; id(1, ADD, 0, 6, 5, 2); #1;
    `CHK("lu_stall", stall_out, 1);
    `CHK("lu_flush", flush_out, 0);
    `CHK("lu_ex_ld", ex_alu_control, 8'h0C);
    `CHK("lu_sel_b", ex_sel_b, 1);
    tick; #1;
    `CHK("lu_bubble", ex_alu_control, 8'h0F);
    `CHK("lu_mem_re", mem_re, 1);
    `CHK("lu_stall_once", stall_out, 0);
    tick; id(0, NOP, 0, 0, 0, 0); #1;
    `CHK("lu_add_late", ex_alu_control, 8'h00);
    `CHK("lu_mem_re_off", mem_re, 0);
    `CHK("lu_wb_we", wb_reg_we, 1);
    `CHK("lu_wb_sel", wb_sel_data_out, 1);
    `CHK("lu_wb_rd", wb_rd, 5);

    id(1, LD, 0, 5, 1, 0);
    tick; id(1, LD, 0, 5, 5, 0); #1;
    `CHK("bb_stall1", stall_out, 1);
    tick; #1;
    `CHK("bb_gap", stall_out, 0);
    tick; id(1, ADD, 0, 7, 5, 5); #1;
    `CHK("bb_stall2", stall_out, 1);
    tick; id(0, NOP, 0, 0, 0, 0);
    tick; tick; tick; #1;

    id(1, BT, 2'b10, 0, 0, 0); #1;
    `CHK("bt_re_a", id_re_a, 0);
    tick; id(1, OR_, 0, 9, 1, 2); branch_cond = 1'b0; #1;
    `CHK("nt_ex_branch", ex_branch, 1);
    `CHK("nt_ex_alu", ex_alu_control, 8'h2E);
    `CHK("nt_flush", flush_out, 0);
    tick; id(0, NOP, 0, 0, 0, 0); #1;
    `CHK("nt_or_in_ex", ex_alu_control, 8'h04);
    tick; tick; tick;

    id(1, BT, 2'b10, 0, 0, 0);
    tick; id(1, ST, 0, 0, 1, 2); branch_cond = 1'b1; #1;
    `CHK("tk_flush1", flush_out, 1);
    `CHK("tk_stall", stall_out, 0);
    tick; branch_cond = 1'b0; id(1, ADD, 0, 7, 1, 2); #1;
    `CHK("tk_flush2", flush_out, 1);
    `CHK("tk_bubble1", ex_alu_control, 8'h0F);
    tick; id(1, SUB, 0, 8, 1, 2); #1;
    `CHK("tk_flush_end", flush_out, 0);
    `CHK("tk_bubble2", ex_alu_control, 8'h0F);
    `CHK("tk_no_st", mem_we, 0);
    `CHK("tk_bt_wb", wb_reg_we, 0);
    tick; id(0, NOP, 0, 0, 0, 0); #1;
    `CHK("tk_sub_in_ex", ex_alu_control, 8'h01);
    `CHK("tk_no_add_wb", wb_reg_we, 0);
    tick; tick; tick;

    id(1, LD, 0, 4, 1, 0);
    tick; id(1, ADD, 0, 6, 0, 4); mem_busy = 1'b1; #1;
    `CHK("mb_stall", stall_out, 1);
    `CHK("mb_ex", ex_alu_control, 8'h0C);
    tick; #1;
    `CHK("mb_frz1_ex", ex_alu_control, 8'h0C);
    `CHK("mb_frz1_mem", mem_re, 0);
    tick; #1;
    `CHK("mb_frz2_ex", ex_alu_control, 8'h0C);
    `CHK("mb_frz2_stall", stall_out, 1);
    tick; mem_busy = 1'b0; #1;
    `CHK("mb_frz3_ex", ex_alu_control, 8'h0C);
    `CHK("mb_frz3_mem", mem_re, 0);
    `CHK("mb_rel_stall", stall_out, 1);
    tick; #1;
    `CHK("mb_bubble", ex_alu_control, 8'h0F);
    `CHK("mb_mem_re", mem_re, 1);
    `CHK("mb_stall_off", stall_out, 0);
    tick; id(0, NOP, 0, 0, 0, 0); #1;
    `CHK("mb_add_ex", ex_alu_control, 8'h00);
    tick; tick; tick;

    id(1, LD, 0, 2, 1, 0);
    tick; id(1, BT, 2'b01, 0, 0, 0); #1;
    `CHK("fs_bt_nostall", stall_out, 0);
    tick; id(1, ADD, 0, 6, 2, 3); branch_cond = 1'b1; #1;
    `CHK("fs_flush", flush_out, 1);
    `CHK("fs_stall", stall_out, 0);
    tick; branch_cond = 1'b0; #1;
    `CHK("fs_flush2", flush_out, 1);
    `CHK("fs_wb_ld", wb_reg_we, 1);
    #1 rst = 1'b1; #1;
    `CHK("mrst_flush", flush_out, 0);
    `CHK("mrst_wb_we", wb_reg_we, 0);
    `CHK("mrst_ex_alu", ex_alu_control, 8'h0F);
    @(negedge clk); rst = 1'b0; id(0, NOP, 0, 0, 0, 0);
    tick; #1;
    `CHK("mrst_cnt_abort", flush_out, 0);

    id(1, ADD, 0, 3, 1, 2);
    tick; id(0, NOP, 0, 0, 0, 0); #1;
    `CHK("ar_ex_add", ex_alu_control, 8'h00);
    #2 rst = 1'b1; #1;
    `CHK("ar_ex_alu", ex_alu_control, 8'h0F);
    `CHK("ar_stall", stall_out, 0);
    @(negedge clk); rst = 1'b0;
    tick; #1;
    `CHK("ar_wb_we", wb_reg_we, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_control.md
Name: pipelined_control

Overview:
- Pipelined successor to the combinational opcode decoder.
- Decodes the ID-stage instruction and carries its control bundle through EX, MEM and WB registers.
- Detects load-use hazards and inserts bubbles; flushes younger instructions on a taken branch.
- Sits between fetch/ID and the datapath; drives stage-aligned enables to ALU, data memory and register file.

Parameters:
- REG_ADDR_W, 4, register-index width.
- CMP_W, 2, compare-mode field width; ALU control width is CMP_W+4.
- FLUSH_CYCLES, 1, number of bubbles injected after a taken branch (1..3).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_opcode  in  4  opcode of the ID instruction
- id_cmp_flag  in  CMP_W  compare mode (00 NOP, 01 LT, 10 EQ, 11 LE)
- id_rd / id_ra / id_rb  in  REG_ADDR_W  destination and source indices
- branch_cond  in  1  compare-flag result from EX datapath, valid same cycle
- mem_busy  in  1  memory not ready; freezes the whole pipeline
- id_re_a / id_re_b  out  1  register-file read enables (combinational from ID)
- stall_out  out  1  hold PC and ID register
- flush_out  out  1  discard instruction in ID/fetch
- ex_alu_control  out  CMP_W+4  {cmp_flag, opcode}
- ex_sel_b  out  2  0 ALU, 1 load offset, 2 store offset
- ex_alu_mux  out  1  immediate select (MOV)
- ex_cmp_en  out  1  compare enable
- ex_branch  out  1  BT in EX
- mem_we / mem_re  out  1  data memory write / read enable
- wb_reg_we  out  1  register write enable
- wb_sel_data_out  out  1  0 ALU result, 1 load data
- wb_rd  out  REG_ADDR_W  writeback index

Behaviour:
- Opcode map:
  - 0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, 5 XOR, 6 NOT, 7 MAX.
  - 8 CMP, 9 SLL, A SRL, B MOV, C LD, D ST, E BT, F NOP.
- Decode rules:
  - re_a is 0 for MOV, BT, NOP.
  - re_b is 0 for NOT, MOV, LD, BT, NOP.
  - reg_we is 0 for CMP, ST, BT, NOP.
  - mem_re only for LD; mem_we only for ST; sel_data_out only for LD.
  - id_valid=0 decodes as NOP.
- Bubble bundle: opcode F, cmp 00, every enable 0, rd 0.
- Reset (async): EX, MEM and WB registers load the bubble bundle, so every ex_/mem_/wb_ output is 0 and ex_alu_control=0x0F. The flush counter clears and stall_out=flush_out=0.
- Latency: ex_* valid 1 clk after ID acceptance, mem_* after 2 clk, wb_* after 3 clk.
- Load-use hazard:
  - Condition: EX holds LD, and ex_rd == id_ra with id_re_a, or ex_rd == id_rb with id_re_b.
  - stall_out=1 for one cycle; EX loads the bubble; MEM and WB advance.
- Taken branch:
  - Condition: ex_branch & branch_cond.
  - flush_out=1; EX loads the bubble in place of the ID instruction.
  - Counter keeps flush_out=1 and injects bubbles for FLUSH_CYCLES total cycles.
  - BT itself continues to MEM/WB with no side effects.
- Priority: mem_busy > flush > load-use stall.
  - mem_busy: all stage registers hold; no bubble; stall_out=1; flush counter frozen.
  - Flush and stall in the same cycle: flush wins, stall_out=0.
- Branch with branch_cond=0: no action.
- Back-to-back loads to the same rd: each stalls independently.
- Reset mid-flush: counter aborts to 0.
- Only LD causes a stall; all other RAW hazards are covered by datapath forwarding outside this block.

Optional Feature:
- Macro: PIPE_CTRL_PERF_CNT_EN.
- Defined: adds 16-bit saturating outputs stall_cnt and flush_cnt, each incremented per stalled or flushed cycle and cleared by rst.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package: opcode localparams, the ctrl_bundle_t struct (alu_control, sel_b, alu_mux, cmp_en, branch, mem_we, mem_re, reg_we, sel_data_out, rd) and the BUBBLE constant.
- Sub-module ctrl_decode: purely combinational opcode-to-bundle decoder, instantiated once at ID.

Test Plan:
- Reset:
  - Stimulus: assert rst mid-stream with ADD in EX.
  - Required: all enables 0 immediately (async); ex_alu_control=0x0F.
- Straight-line ADD:
  - Stimulus: ADD rd=3 issued at cycle 0.
  - Required: ex_alu_control=0x00 at cycle 1; wb_reg_we=1 and wb_rd=3 at cycle 3; stall_out never asserted.
- Load-use:
  - Stimulus: LD rd=5, then ADD ra=5.
  - Required: stall_out=1 for exactly one cycle; one bubble in EX; ADD reaches EX one cycle late; mem_re=1 two cycles after LD issue.
- Taken branch, FLUSH_CYCLES=2:
  - Stimulus: BT in EX with branch_cond=1.
  - Required: flush_out=1 for 2 cycles; two bubbles; no reg_we or mem_we from the flushed instructions.
- Simultaneous events:
  - Stimulus: mem_busy=1 for 3 cycles during a load-use hazard.
  - Required: outputs frozen throughout; then exactly one bubble after release.
- Flush vs stall:
  - Stimulus: taken BT in EX while ID holds ADD ra=rd of an older LD.
  - Required: flush wins; stall_out=0.
